// File: rtl/io_regfile_pkg.sv
// Shared register map defaults for the CPU wrapper and the I/O peripherals.
// Keeps the button and export window bases consistent across the codebase.
package io_regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int BTN_BASE_DEF   = 1;
  localparam int OUT_BASE_DEF   = 11;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/io_regfile_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
// rise is high in the cycle whose closing edge flips db from 0 to 1.
module btn_debounce
  import io_regfile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic btn_raw,
  output logic db,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  assign rise = sync2 & ~db & (cnt == CNT_LAST);

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // Any cycle agreeing with the current level restarts the count.
      if (sync2 != db) begin
        if (cnt == CNT_LAST) begin
          db  <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/io_regfile.sv
// Register file with a debounced push-button read window and an exported register window.
// Reads are combinational with write-through bypass on ordinary registers only.
module io_regfile
  import io_regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int NUM_BTN         = 4,
  parameter int BTN_BASE        = BTN_BASE_DEF,
  parameter int NUM_OUT         = 4,
  parameter int OUT_BASE        = OUT_BASE_DEF,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                          clock,
  input  logic                          ctrl_reset,
  input  logic                          ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
  input  logic [ADDR_WIDTH-1:0]         ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]         ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0]         data_writeReg,
  output logic [DATA_WIDTH-1:0]         data_readRegA,
  output logic [DATA_WIDTH-1:0]         data_readRegB,
  input  logic [NUM_BTN-1:0]            btn_in,
  input  logic                          io_mode,
  output logic [NUM_OUT*DATA_WIDTH-1:0] reg_export
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  if (NUM_BTN < 1 || BTN_BASE < 1 || BTN_BASE + NUM_BTN > NUM_REGS) begin : g_btn_range_bad
    $fatal(1, "io_regfile: button window outside 1..%0d", NUM_REGS - 1);
  end
  if (NUM_OUT < 1 || OUT_BASE < 1 || OUT_BASE + NUM_OUT > NUM_REGS) begin : g_out_range_bad
    $fatal(1, "io_regfile: export window outside 1..%0d", NUM_REGS - 1);
  end
  if (BTN_BASE < OUT_BASE + NUM_OUT && OUT_BASE < BTN_BASE + NUM_BTN) begin : g_overlap_bad
    $fatal(1, "io_regfile: button and export windows overlap");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_bad
    $fatal(1, "io_regfile: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_BTN-1:0]    db;
  logic [NUM_BTN-1:0]    rise;
  logic [NUM_BTN-1:0]    sticky;
  logic [NUM_BTN-1:0]    sticky_clr;
  logic [NUM_BTN-1:0]    btn_view;

  function automatic logic is_btn(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) >= BTN_BASE) && (int'(a) < BTN_BASE + NUM_BTN);
  endfunction

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .btn_raw    (btn_in[b]),
      .db         (db[b]),
      .rise       (rise[b])
    );
    assign sticky_clr[b] = ctrl_writeEnable & io_mode & (int'(ctrl_writeReg) == BTN_BASE + b);
  end

  // Set takes priority so a press landing on the acknowledge write is kept.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | rise;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (ctrl_writeEnable && ctrl_writeReg != '0 && !is_btn(ctrl_writeReg)) begin
      mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign btn_view = io_mode ? sticky : db;

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    if (a == '0) begin
      r = '0;
    end else if (is_btn(a)) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        if (int'(a) == BTN_BASE + b) begin
          r = DATA_WIDTH'(btn_view[b]);
        end
      end
    end else if (ctrl_writeEnable && ctrl_writeReg == a) begin
      r = data_writeReg;
    end else begin
      r = mem[a];
    end
    return r;
  endfunction

  always_comb begin
    data_readRegA = read_port(ctrl_readRegA);
    data_readRegB = read_port(ctrl_readRegB);
  end

  // Peripherals see committed values only, never the in-flight write.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_export
    assign reg_export[i*DATA_WIDTH +: DATA_WIDTH] = mem[OUT_BASE + i];
  end

endmodule

// File: tb/tb_io_regfile.sv
// Randomised and directed bench for io_regfile with a window-based behavioural model.
module tb_io_regfile;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NB  = 4;
  localparam int BB  = 1;
  localparam int NO  = 4;
  localparam int OB  = 11;
  localparam int DEB = 4;

  logic              clock;
  logic              ctrl_reset;
  logic              ctrl_writeEnable;
  logic [AW-1:0]     ctrl_writeReg;
  logic [AW-1:0]     ctrl_readRegA;
  logic [AW-1:0]     ctrl_readRegB;
  logic [DW-1:0]     data_writeReg;
  logic [DW-1:0]     data_readRegA;
  logic [DW-1:0]     data_readRegB;
  logic [NB-1:0]     btn_in;
  logic              io_mode;
  logic [NO*DW-1:0]  reg_export;

  io_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BTN(NB), .BTN_BASE(BB),
    .NUM_OUT(NO), .OUT_BASE(OB), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .btn_in           (btn_in),
    .io_mode          (io_mode),
    .reg_export       (reg_export)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Model: stored values, debounced levels, sticky bits and the raw sample history.
  logic [DW-1:0] m_mem [2**AW];
  logic [NB-1:0] m_db;
  logic [NB-1:0] m_sticky;
  logic [7:0]    hist [NB];
  logic          all_diff;

  function automatic bit in_btn(input logic [AW-1:0] a);
    return int'(a) >= BB && int'(a) < BB + NB;
  endfunction

  // db flips once the last DEB synchronised samples all disagree with it.
  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
      m_db = '0;
      m_sticky = '0;
      for (int b = 0; b < NB; b++) hist[b] = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DEB; k++) if (hist[b][k] == m_db[b]) all_diff = 1'b0;
        if (all_diff && !m_db[b]) m_sticky[b] = 1'b1;
        else if (ctrl_writeEnable && io_mode && int'(ctrl_writeReg) == BB + b) m_sticky[b] = 1'b0;
        if (all_diff) m_db[b] = ~m_db[b];
        hist[b] = {hist[b][6:0], btn_in[b]};
      end
      if (ctrl_writeEnable && ctrl_writeReg != '0 && !in_btn(ctrl_writeReg))
        m_mem[ctrl_writeReg] = data_writeReg;
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (in_btn(a)) return DW'(io_mode ? m_sticky[int'(a) - BB] : m_db[int'(a) - BB]);
    if (ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
    return m_mem[a];
  endfunction

  task automatic chk(input string name, input logic [NO*DW-1:0] act, input logic [NO*DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("cyc_rdA", data_readRegA, exp_read(ctrl_readRegA));
      chk("cyc_rdB", data_readRegB, exp_read(ctrl_readRegB));
      for (int i = 0; i < NO; i++)
        chk("cyc_export", reg_export[i*DW +: DW], m_mem[OB + i]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    ctrl_readRegA = a;
    #1;
    chk(name, data_readRegA, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
  endtask

  initial begin
    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg = '0;
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    data_writeReg = '0;
    btn_in = '0;
    io_mode = 1'b0;
    step();
    step();
    ctrl_reset = 1'b0;
    chk_on = 1'b1;

    rd_chk("rst_r7", 7, 0);
    chk("rst_export", reg_export, '0);

    wr(7, 32'hDEADBEEF);
    rd_chk("bypass_r7", 7, 32'hDEADBEEF);
    step();
    ctrl_writeEnable = 1'b0;
    rd_chk("stored_r7", 7, 32'hDEADBEEF);

    wr(0, 32'h1234);
    rd_chk("r0_write_cycle", 0, 0);
    step();
    ctrl_writeEnable = 1'b0;
    rd_chk("r0_after", 0, 0);

    wr(12, 5);
    #1 chk("export_write_cycle", reg_export[1*DW +: DW], 0);
    step();
    ctrl_writeEnable = 1'b0;
    chk("export_next_edge", reg_export[1*DW +: DW], 5);

    // btn_in[0] set just after edge k-1; db must rise at edge k+5.
    io_mode = 1'b0;
    btn_in[0] = 1'b1;
    repeat (5) step();
    rd_chk("db_before", 1, 0);
    step();
    rd_chk("db_rise", 1, 1);

    btn_in[1] = 1'b1;
    repeat (3) step();
    btn_in[1] = 1'b0;
    repeat (8) step();
    rd_chk("glitch_level", 2, 0);
    io_mode = 1'b1;
    rd_chk("glitch_sticky", 2, 0);

    btn_in[2] = 1'b1;
    repeat (8) step();
    btn_in[2] = 1'b0;
    repeat (8) step();
    rd_chk("sticky_held", 3, 1);
    wr(3, 0);
    step();
    ctrl_writeEnable = 1'b0;
    rd_chk("sticky_cleared", 3, 0);

    btn_in[2] = 1'b1;
    repeat (5) step();
    rd_chk("simul_pre", 3, 0);
    wr(3, 32'hFFFF);
    step();
    ctrl_writeEnable = 1'b0;
    rd_chk("simul_set_wins", 3, 1);
    btn_in[2] = 1'b0;

    btn_in[0] = 1'b0;
    repeat (8) step();
    io_mode = 1'b1;
    rd_chk("mode_sticky", 1, 1);
    io_mode = 1'b0;
    rd_chk("mode_level", 1, 0);
    io_mode = 1'b1;
    rd_chk("mode_sticky_again", 1, 1);

    io_mode = 1'b0;
    wr(1, 0);
    step();
    ctrl_writeEnable = 1'b0;
    io_mode = 1'b1;
    rd_chk("mode0_write_ignored", 1, 1);

    step();
    #1 ctrl_reset = 1'b1;
    rd_chk("arst_r7", 7, 0);
    chk("arst_export", reg_export, '0);
    wr(5, 32'h55);
    step();
    ctrl_writeEnable = 1'b0;
    ctrl_reset = 1'b0;
    rd_chk("rst_write_dropped", 5, 0);
    rd_chk("rst_sticky", 1, 0);

    repeat (1500) begin
      ctrl_writeEnable = 1'($urandom_range(0, 1));
      ctrl_writeReg    = AW'($urandom);
      data_writeReg    = $urandom;
      ctrl_readRegA    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : AW'($urandom);
      ctrl_readRegB    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : AW'($urandom);
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 5) == 0) btn_in[b] = ~btn_in[b];
      if ($urandom_range(0, 19) == 0) io_mode = ~io_mode;
      ctrl_reset = ($urandom_range(0, 199) == 0);
      step();
    end
    ctrl_reset = 1'b0;
    step();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/io_regfile.md
Name: io_regfile

Overview:
- Parametrised processor register file with memory-mapped input and output registers.
- A contiguous window of registers reads debounced push-button inputs. Those inputs are either live levels or sticky press events, selected by a mode input.
- A second window of ordinary registers is exported as a flat bus to peripheral logic (speed/direction control).
- Sits between the pipeline's decode/writeback stages and the board I/O.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, address bits; register count = 2**ADDR_WIDTH
NUM_BTN, 4, number of button inputs and button-mapped registers
BTN_BASE, 1, address of the first button register
NUM_OUT, 4, number of exported registers
OUT_BASE, 11, address of the first exported register
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes (>=1)

Ports:
clock  in  1  system clock; all state updates on the rising edge
ctrl_reset  in  1  asynchronous, active-high reset
ctrl_writeEnable  in  1  write strobe
ctrl_writeReg  in  ADDR_WIDTH  write address
ctrl_readRegA  in  ADDR_WIDTH  read port A address
ctrl_readRegB  in  ADDR_WIDTH  read port B address
data_writeReg  in  DATA_WIDTH  write data
data_readRegA  out  DATA_WIDTH  read port A data (combinational)
data_readRegB  out  DATA_WIDTH  read port B data (combinational)
btn_in  in  NUM_BTN  raw, asynchronous button levels
io_mode  in  1  0 = level mode, 1 = sticky-event mode
reg_export  out  NUM_OUT*DATA_WIDTH  slice i = register OUT_BASE+i

Behaviour:
- Reset (asynchronous, active-high): clears all storage registers, synchroniser flops, debounced levels, debounce counters and sticky bits.
- After reset, data_readRegA/B = 0 (except bypass, below) and reg_export = 0.
- Register 0: reads 0 always; writes ignored.
- Ordinary registers (not 0, not the button window):
  - written at the rising edge when ctrl_writeEnable=1.
  - Reads are combinational.
  - Write-through bypass: if readReg == writeReg, writeEnable=1 and the address is non-zero, the read returns data_writeReg in the same cycle.
- reg_export: driven from stored register values only, with no bypass; it updates the edge after a write.
- Button path, per bit b:
  - 2-flop synchroniser sync1 -> sync2.
  - Debounce counter, evaluated each edge:
    - if sync2 != db: if cnt == DEBOUNCE_CYCLES-1 then db <= sync2 and cnt <= 0, else cnt <= cnt+1.
    - if sync2 == db: cnt <= 0.
  - Counter width = clog2(DEBOUNCE_CYCLES), minimum 1.
  - Latency: btn_in high before edge k -> db rises at edge k+1+DEBOUNCE_CYCLES.
  - Any bounce back to the old level restarts the count; pulses shorter than DEBOUNCE_CYCLES never reach db.
  - sticky[b] sets on the same edge that db rises 0->1. Falling db does not affect sticky.
- Button register BTN_BASE+b reads zero-extended to DATA_WIDTH:
  - io_mode=0: reads db[b].
  - io_mode=1: reads sticky[b].
  - No bypass on button addresses.
- Writes to a button address:
  - Data is never stored.
  - io_mode=1: any write clears sticky[b] at that edge.
  - io_mode=0: write ignored; sticky[b] unchanged.
- Simultaneous sticky set and clear in the same cycle: set wins, so no press is lost.
- Sticky bits keep setting in both modes; a mode change never alters stored state.
- Elaboration checks (fatal on failure):
  - the button and export windows lie within 1..2**ADDR_WIDTH-1;
  - the two windows do not overlap;
  - DEBOUNCE_CYCLES >= 1.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults and the window base constants (BTN_BASE, OUT_BASE), so CPU wrapper and peripherals agree on the map.
- One sub-module: btn_debounce (synchroniser + counter + db + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated NUM_BTN times.
- Storage and read muxing stay in io_regfile.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset: assert ctrl_reset mid-run -> all reads 0, reg_export 0 immediately and asynchronously; write to reg 5 during reset is not stored.
- Basic/zero/bypass:
  - write 0xDEADBEEF to reg 7 -> readRegA=7 returns it in the same cycle and after.
  - write 0x1234 to reg 0 -> reads 0.
- Debounce: btn_in[0] high at edge k -> reg 1 reads 1 (io_mode=0) from edge k+5. A 3-cycle glitch on btn_in[1] -> reg 2 stays 0.
- Sticky:
  - io_mode=1: press and release btn_in[2] -> reg 3 reads 1 after release.
  - write 0 to reg 3 -> reads 0.
  - write to reg 3 on the same edge as a new debounced rise -> reads 1.
- Export: write 5 to reg 12 -> reg_export slice 1 = 5 from the next edge, not in the write cycle.
- Mode switch: sticky[0]=1, io_mode 1->0 -> reg 1 shows db level; switch back -> reads 1 again.
